// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit logic unit with a valid/ready handshake.
// Pair mode gives one result per beat; accumulate mode folds a burst of beats into one result.
module logic_gate_unit #(
    parameter  int WIDTH     = 8,
    parameter  int MAX_BEATS = 16,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_any,
    output logic             y_all,
    output logic [CW-1:0]    beat_count,
    output logic             overflow
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_y;
    logic [CW-1:0]    r_beat_count;
    logic             r_overflow;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_fire;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_fold;
    logic [CW-1:0]    w_count_next;

    // x is always the incoming beat, so PASS_A/NOT_A follow the latest beat when folding
    function automatic logic [WIDTH-1:0] f_apply(input logic [2:0] sel,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] res;
        res = '0;
        case (sel)
            3'b000:  res = x & z;
            3'b001:  res = x | z;
            3'b010:  res = x ^ z;
            3'b011:  res = ~(x & z);
            3'b100:  res = ~(x | z);
            3'b101:  res = ~(x ^ z);
            3'b110:  res = x;
            default: res = ~x;
        endcase
        return res;
    endfunction

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready = !r_out_valid || out_ready;
            S_ACCUM: w_in_ready = 1'b1;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept     = in_valid && w_in_ready;
    assign w_fire       = r_out_valid && out_ready;
    assign w_first      = f_apply(op, a, b);
    assign w_fold       = f_apply(r_op, a, r_acc);
    assign w_count_next = r_count + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_acc        <= '0;
            r_count      <= '0;
            r_y          <= '0;
            r_beat_count <= '0;
            r_overflow   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !mode) begin
                        r_y          <= w_first;
                        r_beat_count <= CW'(1);
                        r_overflow   <= 1'b0;
                        r_out_valid  <= 1'b1;
                    end else if (w_accept) begin
                        r_op    <= op;
                        r_acc   <= w_first;
                        r_count <= CW'(1);
                        if (in_last) begin
                            r_y          <= w_first;
                            r_beat_count <= CW'(1);
                            r_overflow   <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_OUT;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_ACCUM;
                        end
                    end else if (w_fire) begin
                        r_out_valid <= 1'b0;
                    end
                end
                // A burst that reaches MAX_BEATS without in_last is cut short and flagged
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_fold;
                        r_count <= w_count_next;
                        if (in_last || (w_count_next == CW'(MAX_BEATS))) begin
                            r_y          <= w_fold;
                            r_beat_count <= w_count_next;
                            r_overflow   <= !in_last;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (w_fire) begin
                        r_out_valid <= 1'b0;
                        r_op        <= '0;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign y          = r_y;
    assign y_any      = |r_y;
    assign y_all      = &r_y;
    assign beat_count = r_beat_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed scenarios plus randomized
// pair/burst traffic scored against a truth-table reference model.
module tb_logic_gate_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       inValid, inReady, modeIn, lastIn, outValid, outReady, yAny, yAll, overflow;
    logic [7:0] aIn, bIn, y;
    logic [2:0] opIn, beatCount;

    logic       inValid1, inReady1, a1, b1, modeIn1, lastIn1, outValid1, outReady1, y1, yAny1, yAll1, ovf1;
    logic [2:0] opIn1;
    logic [1:0] bc1;

    int errors = 0;
    int checks = 0;

    logic_gate_unit #(.WIDTH(8), .MAX_BEATS(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .a(aIn), .b(bIn), .op(opIn), .mode(modeIn), .in_last(lastIn),
        .out_valid(outValid), .out_ready(outReady), .y(y), .y_any(yAny),
        .y_all(yAll), .beat_count(beatCount), .overflow(overflow)
    );

    logic_gate_unit #(.WIDTH(1), .MAX_BEATS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .in_ready(inReady1),
        .a(a1), .b(b1), .op(opIn1), .mode(modeIn1), .in_last(lastIn1),
        .out_valid(outValid1), .out_ready(outReady1), .y(y1), .y_any(yAny1),
        .y_all(yAll1), .beat_count(bc1), .overflow(ovf1)
    );

    // Reference op: each result bit looked up in a 4-entry truth table indexed by {x,z}
    function automatic logic [7:0] refOp(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        logic [3:0] tt;
        logic [7:0] r;
        case (o)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b0111;
            3'd4: tt = 4'b0001;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b1100;
            default: tt = 4'b0011;
        endcase
        for (int i = 0; i < 8; i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setBeat(input logic v, input logic [7:0] av, input logic [7:0] bv,
                           input logic [2:0] ov, input logic mv, input logic lv);
        inValid = v; aIn = av; bIn = bv; opIn = ov; modeIn = mv; lastIn = lv;
    endtask

    task automatic driveBeat(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] ov,
                             input logic mv, input logic lv, output bit ok);
        int n;
        setBeat(1'b1, av, bv, ov, mv, lv);
        n = 0;
        @(negedge clk);
        while (!inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = inReady;
        step();
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({outValid, inReady, y, beatCount, overflow, yAny, yAll} !== {1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset: got v=%b r=%b y=%h bc=%0d ovf=%b", outValid, inReady, y, beatCount, overflow);
        end
        checks++;
        if ({outValid1, inReady1, y1, bc1} !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL reset_w1: got v=%b r=%b y=%b bc=%0d", outValid1, inReady1, y1, bc1);
        end
    endtask

    task automatic test_width1_or();
        logic exp1 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        outReady1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab = 2'(i);
            inValid1 = 1'b1; a1 = ab[1]; b1 = ab[0];
            step();
            checks++;
            if ({outValid1, y1, bc1} !== {1'b1, exp1[i], 2'd1}) begin
                errors++;
                $display("[TB] FAIL w1_or%0d: got v=%b y=%b bc=%0d want v=1 y=%b bc=1", i, outValid1, y1, bc1, exp1[i]);
            end
        end
        inValid1 = 1'b0;
        step();
        checks++;
        if (outValid1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w1_drain: got v=%b want 0", outValid1);
        end
    endtask

    task automatic test_pair_ops();
        logic [7:0] pairExp [8] = '{8'h0C, 8'h3F, 8'h33, 8'hF3, 8'hC0, 8'hCC, 8'h0F, 8'hF0};
        outReady = 1'b1;
        for (int o = 0; o < 8; o++) begin
            setBeat(1'b1, 8'h0F, 8'h3C, 3'(o), 1'b0, 1'b0);
            step();
            checks++;
            if ({outValid, inReady, y, beatCount, overflow} !== {1'b1, 1'b1, pairExp[o], 3'd1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL pair_op%0d: got v=%b y=%h bc=%0d ovf=%b want y=%h", o, outValid, y, beatCount, overflow, pairExp[o]);
            end
            if (o == 1) begin
                checks++;
                if ({yAny, yAll} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL pair_or_reduce: got any=%b all=%b want 1 0", yAny, yAll);
                end
            end
        end
        inValid = 1'b0;
        step();
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pair_drain: got v=%b want 0", outValid);
        end
    endtask

    task automatic test_backpressure();
        outReady = 1'b0;
        setBeat(1'b1, 8'h01, 8'h02, 3'd1, 1'b0, 1'b0);
        step();
        setBeat(1'b1, 8'h10, 8'h20, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({outValid, inReady, y} !== {1'b1, 1'b0, 8'h03}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got v=%b r=%b y=%h want v=1 r=0 y=03", i, outValid, inReady, y);
            end
            step();
        end
        outReady = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ready: got %b want 1", inReady);
        end
        step();
        inValid = 1'b0;
        checks++;
        if ({outValid, y} !== {1'b1, 8'h30}) begin
            errors++;
            $display("[TB] FAIL bp_next: got v=%b y=%h want v=1 y=30", outValid, y);
        end
        step();
    endtask

    task automatic test_accum_xor();
        outReady = 1'b0;
        setBeat(1'b1, 8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
        step();
        checks++;
        if ({outValid, inReady} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL acc_busy: got v=%b r=%b want 0 1", outValid, inReady);
        end
        setBeat(1'b1, 8'h04, 8'hFF, 3'd0, 1'b0, 1'b0);
        step();
        setBeat(1'b1, 8'h08, 8'hFF, 3'd3, 1'b0, 1'b1);
        step();
        inValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({outValid, inReady, y, beatCount, overflow} !== {1'b1, 1'b0, 8'h0F, 3'd3, 1'b0}) begin
                errors++;
                $display("[TB] FAIL acc_xor%0d: got v=%b r=%b y=%h bc=%0d ovf=%b want y=0f bc=3", i, outValid, inReady, y, beatCount, overflow);
            end
            step();
        end
        outReady = 1'b1;
        step();
        checks++;
        if ({outValid, inReady} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL acc_release: got v=%b r=%b want 0 1", outValid, inReady);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] as [4] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F};
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setBeat(1'b1, as[i], 8'hFE, 3'd0, 1'b1, 1'b0);
            step();
        end
        setBeat(1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({outValid, inReady, y, beatCount, overflow} !== {1'b1, 1'b0, 8'h1E, 3'd4, 1'b1}) begin
                errors++;
                $display("[TB] FAIL ovf_hold%0d: got v=%b r=%b y=%h bc=%0d ovf=%b want y=1e bc=4 ovf=1", i, outValid, inReady, y, beatCount, overflow);
            end
            step();
        end
        outReady = 1'b1;
        step();
        checks++;
        if ({outValid, inReady} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ovf_idle: got v=%b r=%b want 0 1", outValid, inReady);
        end
        step();
        inValid = 1'b0;
        checks++;
        if ({outValid, y, beatCount, overflow} !== {1'b1, 8'h33, 3'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ovf_next: got v=%b y=%h bc=%0d ovf=%b want y=33 bc=1", outValid, y, beatCount, overflow);
        end
        step();
    endtask

    task automatic test_reset_midburst();
        outReady = 1'b1;
        setBeat(1'b1, 8'h01, 8'h02, 3'd1, 1'b1, 1'b0);
        step();
        setBeat(1'b1, 8'h04, 8'h00, 3'd1, 1'b1, 1'b0);
        step();
        inValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({outValid, inReady, y, beatCount, overflow} !== {1'b0, 1'b1, 8'h00, 3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b r=%b y=%h bc=%0d ovf=%b", outValid, inReady, y, beatCount, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        setBeat(1'b1, 8'hAA, 8'h0F, 3'd0, 1'b0, 1'b0);
        step();
        inValid = 1'b0;
        checks++;
        if ({outValid, y, beatCount, overflow} !== {1'b1, 8'h0A, 3'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL post_reset_pair: got v=%b y=%h bc=%0d want y=0a bc=1", outValid, y, beatCount);
        end
        step();
    endtask

    task automatic test_random();
        logic [7:0] expY [$];
        logic [2:0] expC [$];
        logic       expO [$];
        int nTx = 40;
        int got = 0;
        fork
            begin
                for (int t = 0; t < nTx; t++) begin
                    logic [2:0] o = 3'($urandom_range(0, 7));
                    logic [7:0] av = 8'($urandom);
                    logic [7:0] bv = 8'($urandom);
                    bit ok;
                    if ($urandom_range(0, 1) == 0) begin
                        expY.push_back(refOp(o, av, bv)); expC.push_back(3'd1); expO.push_back(1'b0);
                        driveBeat(av, bv, o, 1'b0, 1'($urandom), ok);
                        checks++;
                        if (!ok) begin errors++; $display("[TB] FAIL rnd_accept%0d: in_ready never rose", t); end
                    end else begin
                        int len = $urandom_range(1, 4);
                        bit cut = (len == 4) && ($urandom_range(0, 1) == 1);
                        logic [7:0] as [4];
                        logic [7:0] acc;
                        as[0] = av;
                        for (int i = 1; i < 4; i++) as[i] = 8'($urandom);
                        acc = refOp(o, as[0], bv);
                        for (int i = 1; i < len; i++) acc = refOp(o, as[i], acc);
                        expY.push_back(acc); expC.push_back(3'(len)); expO.push_back(cut);
                        for (int i = 0; i < len; i++) begin
                            logic lv = (i == len - 1) && !cut;
                            if (i == 0) driveBeat(as[i], bv, o, 1'b1, lv, ok);
                            else driveBeat(as[i], 8'($urandom), 3'($urandom), 1'($urandom), lv, ok);
                            checks++;
                            if (!ok) begin errors++; $display("[TB] FAIL rnd_accept%0d_%0d: in_ready never rose", t, i); end
                        end
                    end
                end
            end
            begin
                int cyc = 0;
                while (got < nTx && cyc < 5000) begin
                    @(negedge clk);
                    if (outValid && outReady) begin
                        checks++;
                        if (expY.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL rnd_spurious: got y=%h with nothing expected", y);
                        end else begin
                            logic [7:0] ey = expY.pop_front();
                            logic [2:0] ec = expC.pop_front();
                            logic       eo = expO.pop_front();
                            if ({y, beatCount, overflow} !== {ey, ec, eo}) begin
                                errors++;
                                $display("[TB] FAIL rnd_result%0d: got y=%h bc=%0d ovf=%b want y=%h bc=%0d ovf=%b", got, y, beatCount, overflow, ey, ec, eo);
                            end
                        end
                        got++;
                    end
                    step();
                    outReady = 1'($urandom);
                    cyc++;
                end
            end
        join
        checks++;
        if (got != nTx) begin
            errors++;
            $display("[TB] FAIL rnd_count: got %0d results want %0d", got, nTx);
        end
        outReady = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        setBeat(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        outReady = 1'b1;
        inValid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; opIn1 = 3'd1; modeIn1 = 1'b0; lastIn1 = 1'b0; outReady1 = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_width1_or();
        test_pair_ops();
        test_backpressure();
        test_accum_xor();
        test_overflow();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
